// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// pll_lock_sequencer: synchronises and qualifies PLL lock, then sequences a
// registered system reset; counts lock losses. Option: PLL_LOCK_SEQ_HEARTBEAT_EN
// Revision: 1.0
// ============================================================================
module pll_lock_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_STABLE = 1024,
  parameter int RESET_HOLD  = 16,
  parameter int LOSS_W      = 8,
  parameter int HB_BIT      = 24
) (
  input  logic              CLK,
  input  logic              BTN_USR,
  input  logic              PLL_LOCK,
  input  logic              CLR_LOSS,
  output logic              SYS_RST_N,
  output logic              READY,
  output logic [LOSS_W-1:0] LOSS_CNT,
  output logic              LOSS_STICKY
`ifdef PLL_LOCK_SEQ_HEARTBEAT_EN
  ,
  output logic              LED_HB
`endif
);

  localparam logic [1:0] c_st_wait   = 2'd0;
  localparam logic [1:0] c_st_stable = 2'd1;
  localparam logic [1:0] c_st_hold   = 2'd2;
  localparam logic [1:0] c_st_run    = 2'd3;

  localparam int c_cnt_max = (LOCK_STABLE > RESET_HOLD) ? LOCK_STABLE : RESET_HOLD;
  localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
  localparam logic [c_cnt_w-1:0] c_stable_last = c_cnt_w'(LOCK_STABLE - 1);
  localparam logic [c_cnt_w-1:0] c_hold_last   = c_cnt_w'(RESET_HOLD - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]             state_q, state_d;
  logic [c_cnt_w-1:0]     cnt_q, cnt_d;
  logic                   rst_n_q, rst_n_d;
  logic                   ready_q, ready_d;
  logic [LOSS_W-1:0]      loss_cnt_q, loss_cnt_d;
  logic                   sticky_q, sticky_d;
  logic                   lock_s;
  logic                   loss_evt;

  assign lock_s   = sync_q[SYNC_STAGES-1];
  assign loss_evt = (state_q == c_st_run) && !lock_s;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], PLL_LOCK};
  end

  // Any drop of the synchronised lock before RUN restarts qualification.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      c_st_wait: begin
        cnt_d = '0;
        if (lock_s) state_d = c_st_stable;
      end
      c_st_stable: begin
        if (!lock_s) begin
          state_d = c_st_wait;
          cnt_d   = '0;
        end else if (cnt_q == c_stable_last) begin
          state_d = c_st_hold;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
        end
      end
      c_st_hold: begin
        if (!lock_s) begin
          state_d = c_st_wait;
          cnt_d   = '0;
        end else if (cnt_q == c_hold_last) begin
          state_d = c_st_run;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
        end
      end
      c_st_run: begin
        cnt_d = '0;
        if (!lock_s) state_d = c_st_wait;
      end
      default: begin
        state_d = c_st_wait;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs register the next state so they change on the same edge as the FSM.
  always_comb begin
    rst_n_d = (state_d == c_st_run);
    ready_d = (state_d == c_st_run);
  end

  // A loss coinciding with a clear wins: the count restarts at one.
  always_comb begin
    loss_cnt_d = loss_cnt_q;
    sticky_d   = sticky_q;
    if (loss_evt) begin
      sticky_d = 1'b1;
      if (CLR_LOSS)
        loss_cnt_d = LOSS_W'(1);
      else if (!(&loss_cnt_q))
        loss_cnt_d = loss_cnt_q + LOSS_W'(1);
    end else if (CLR_LOSS) begin
      loss_cnt_d = '0;
      sticky_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge BTN_USR) begin
    if (!BTN_USR) begin
      sync_q     <= '0;
      state_q    <= c_st_wait;
      cnt_q      <= '0;
      rst_n_q    <= 1'b0;
      ready_q    <= 1'b0;
      loss_cnt_q <= '0;
      sticky_q   <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rst_n_q    <= rst_n_d;
      ready_q    <= ready_d;
      loss_cnt_q <= loss_cnt_d;
      sticky_q   <= sticky_d;
    end
  end

  assign SYS_RST_N   = rst_n_q;
  assign READY       = ready_q;
  assign LOSS_CNT    = loss_cnt_q;
  assign LOSS_STICKY = sticky_q;

`ifdef PLL_LOCK_SEQ_HEARTBEAT_EN
  logic [HB_BIT:0] hb_q, hb_d;

  always_comb begin
    hb_d = '0;
    if ((state_q == c_st_run) && (state_d == c_st_run))
      hb_d = hb_q + (HB_BIT + 1)'(1);
  end

  always_ff @(posedge CLK or negedge BTN_USR) begin
    if (!BTN_USR) hb_q <= '0;
    else          hb_q <= hb_d;
  end

  assign LED_HB = ready_q & hb_q[HB_BIT];
`else
  // HB_BIT only matters when the heartbeat is built in.
  generate
    if (HB_BIT < 0) begin : g_hb_unused
    end
  endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// tb_pll_lock_sequencer: directed and randomized checks of pll_lock_sequencer
// against a run-length reference model. Revision: 1.0
// ============================================================================
module tb_pll_lock_sequencer;

  localparam int SYNC = 2;
  localparam int LS   = 8;
  localparam int RH   = 4;
  localparam int LW   = 2;
  localparam int HB   = 2;
  localparam int SAT  = (1 << LW) - 1;
  localparam int RISE = SYNC + 1 + LS + RH;
  localparam int FALL = SYNC + 1;

  logic          CLK = 1'b0;
  logic          BTN_USR;
  logic          PLL_LOCK;
  logic          CLR_LOSS;
  logic          SYS_RST_N;
  logic          READY;
  logic [LW-1:0] LOSS_CNT;
  logic          LOSS_STICKY;
`ifdef PLL_LOCK_SEQ_HEARTBEAT_EN
  logic          LED_HB;
`endif

  pll_lock_sequencer #(
    .SYNC_STAGES(SYNC),
    .LOCK_STABLE(LS),
    .RESET_HOLD (RH),
    .LOSS_W     (LW),
    .HB_BIT     (HB)
  ) dut (
    .CLK        (CLK),
    .BTN_USR    (BTN_USR),
    .PLL_LOCK   (PLL_LOCK),
    .CLR_LOSS   (CLR_LOSS),
    .SYS_RST_N  (SYS_RST_N),
    .READY      (READY),
    .LOSS_CNT   (LOSS_CNT),
    .LOSS_STICKY(LOSS_STICKY)
`ifdef PLL_LOCK_SEQ_HEARTBEAT_EN
    ,
    .LED_HB     (LED_HB)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: lock is ready once the delayed lock has been seen high
  // for LS+RH+1 consecutive edges.
  bit dq[$];
  int m_run;
  bit m_ready;
  int m_cnt;
  bit m_sticky;
  int m_hb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    dq.delete();
    for (int i = 0; i < SYNC; i++) dq.push_back(1'b0);
    m_run    = 0;
    m_ready  = 1'b0;
    m_cnt    = 0;
    m_sticky = 1'b0;
    m_hb     = 0;
  endfunction

  function automatic void m_edge(input bit lk, input bit clr);
    bit prev_ready;
    bit seen;
    prev_ready = m_ready;
    seen = dq.pop_front();
    dq.push_back(lk);
    if (!seen)              m_run = 0;
    else if (m_run < 10000) m_run = m_run + 1;
    m_ready = (m_run >= LS + RH + 1);
    if (prev_ready && !seen) begin
      m_sticky = 1'b1;
      if (clr)              m_cnt = 1;
      else if (m_cnt < SAT) m_cnt = m_cnt + 1;
    end else if (clr) begin
      m_cnt    = 0;
      m_sticky = 1'b0;
    end
    if (m_ready && prev_ready) m_hb = m_hb + 1;
    else                       m_hb = 0;
  endfunction

  task automatic compare_all(input string ph);
    check({ph, ".sys_rst_n"}, 32'(SYS_RST_N),   32'(m_ready));
    check({ph, ".ready"},     32'(READY),       32'(m_ready));
    check({ph, ".loss_cnt"},  32'(LOSS_CNT),    32'(m_cnt));
    check({ph, ".sticky"},    32'(LOSS_STICKY), 32'(m_sticky));
`ifdef PLL_LOCK_SEQ_HEARTBEAT_EN
    check({ph, ".led_hb"},    32'(LED_HB),      m_ready ? 32'((m_hb >> HB) & 1) : 32'd0);
`endif
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit btn, input bit lk, input bit clr, input string ph);
    BTN_USR  = btn;
    PLL_LOCK = lk;
    CLR_LOSS = clr;
    #1;
    if (!btn) begin
      m_reset();
      compare_all({ph, ".async"});
    end
    @(posedge CLK);
    if (btn) m_edge(lk, clr);
    @(negedge CLK);
    compare_all(ph);
  endtask

  task automatic rise_latency(input string tag);
    int n = 0;
    do begin
      step(1'b1, 1'b1, 1'b0, tag);
      n++;
    end while (SYS_RST_N !== 1'b1 && n < 200);
    check({tag, ".edges"}, 32'(n), 32'(RISE));
    check({tag, ".ready"}, 32'(READY), 32'd1);
  endtask

  task automatic fall_latency(input string tag);
    int n = 0;
    do begin
      step(1'b1, 1'b0, 1'b0, tag);
      n++;
    end while (SYS_RST_N !== 1'b0 && n < 50);
    check({tag, ".edges"}, 32'(n), 32'(FALL));
    check({tag, ".ready"}, 32'(READY), 32'd0);
  endtask

  initial begin
    bit cur_lock;
    int r;
    BTN_USR  = 1'b0;
    PLL_LOCK = 1'b0;
    CLR_LOSS = 1'b0;
    m_reset();
    @(negedge CLK);

    // Power-up with lock already high
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, "por_rst");
    check("por.reset_rst_n", 32'(SYS_RST_N), 32'd0);
    rise_latency("por_rise");
    check("por.loss_cnt", 32'(LOSS_CNT), 32'd0);

    // Early drop during qualification
    step(1'b0, 1'b0, 1'b0, "early_rst");
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, "early_qual");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, "early_drop");
    check("early.ready", 32'(READY), 32'd0);
    rise_latency("early_rise");
    check("early.loss_cnt", 32'(LOSS_CNT), 32'd0);
    check("early.sticky", 32'(LOSS_STICKY), 32'd0);

    // Loss in RUN
    fall_latency("loss1_fall");
    check("loss1.loss_cnt", 32'(LOSS_CNT), 32'd1);
    check("loss1.sticky", 32'(LOSS_STICKY), 32'd1);
    rise_latency("loss1_rise");

    // Saturation after five losses
    for (int i = 0; i < 4; i++) begin
      fall_latency("sat_fall");
      rise_latency("sat_rise");
    end
    check("sat.loss_cnt", 32'(LOSS_CNT), 32'(SAT));
    check("sat.sticky", 32'(LOSS_STICKY), 32'd1);

    // Clear without loss
    step(1'b1, 1'b1, 1'b1, "clr");
    check("clr.loss_cnt", 32'(LOSS_CNT), 32'd0);
    check("clr.sticky", 32'(LOSS_STICKY), 32'd0);
    check("clr.ready", 32'(READY), 32'd1);

    // Clear coinciding with a loss edge
    step(1'b1, 1'b0, 1'b0, "clrloss_a");
    step(1'b1, 1'b0, 1'b0, "clrloss_b");
    step(1'b1, 1'b0, 1'b1, "clrloss_c");
    check("clrloss.loss_cnt", 32'(LOSS_CNT), 32'd1);
    check("clrloss.sticky", 32'(LOSS_STICKY), 32'd1);
    check("clrloss.rst_n", 32'(SYS_RST_N), 32'd0);
    rise_latency("clrloss_rise");

    // Reset during HOLD, then during RUN
    step(1'b0, 1'b1, 1'b0, "hold_pre_rst");
    for (int i = 0; i < 13; i++) step(1'b1, 1'b1, 1'b0, "hold_qual");
    check("hold.rst_n_low", 32'(SYS_RST_N), 32'd0);
    step(1'b0, 1'b1, 1'b0, "hold_rst");
    rise_latency("hold_rise");
    step(1'b0, 1'b1, 1'b0, "run_rst");
    check("run_rst.loss_cnt", 32'(LOSS_CNT), 32'd0);
    rise_latency("run_rise");

    // Randomized lock toggles, glitches, clears and resets
    cur_lock = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bit lk;
      r = int'($urandom_range(0, 39));
      if (r == 0) cur_lock = ~cur_lock;
      lk = (r == 1) ? ~cur_lock : cur_lock;
      step(($urandom_range(0, 299) != 0), lk, ($urandom_range(0, 15) == 0), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Consumes the PLL `locked` indication and produces a clean, sequenced system reset for logic clocked by the PLL output.
- Synchronises the lock input and qualifies it as stable for a programmable time, then holds reset for a further programmable time before release.
- Counts and flags lock-loss events while running.
- Sits between the PLL instance and every PLL-clocked counter or datapath in the top level; replaces ad-hoc `if (PLL_LOCK)` gating in user logic.

Parameters:
- SYNC_STAGES, 2, number of flops in the PLL_LOCK synchroniser chain (minimum 2).
- LOCK_STABLE, 1024, consecutive cycles lock must stay high before reset hold begins (minimum 1).
- RESET_HOLD, 16, cycles SYS_RST_N is held low after lock qualifies (minimum 1).
- LOSS_W, 8, width of the lock-loss counter.
- HB_BIT, 24, heartbeat divider tap bit; used only with the optional feature.

Ports:
- CLK  in  1  PLL output clock; all logic on rising edge.
- BTN_USR  in  1  asynchronous active-low reset; asserts immediately, releases on the next CLK edge.
- PLL_LOCK  in  1  raw PLL locked flag, asynchronous to CLK.
- CLR_LOSS  in  1  synchronous pulse; clears LOSS_CNT and LOSS_STICKY.
- SYS_RST_N  out  1  registered active-low reset for downstream logic.
- READY  out  1  high exactly while the state is RUN.
- LOSS_CNT  out  LOSS_W  saturating count of lock losses seen in RUN.
- LOSS_STICKY  out  1  set on any lock loss in RUN; cleared only by CLR_LOSS or BTN_USR.

Behaviour:
- Reset (BTN_USR=0):
  - Synchroniser flops = 0; state = WAIT_LOCK; internal counters = 0.
  - SYS_RST_N=0, READY=0, LOSS_CNT=0, LOSS_STICKY=0.
- Synchroniser: lock_s is PLL_LOCK delayed through SYNC_STAGES flops. No other logic samples PLL_LOCK directly.
- State machine (one-hot or binary; all outputs registered):
  - WAIT_LOCK:
    - cnt=0.
    - lock_s=1 -> STABILIZE.
  - STABILIZE:
    - cnt increments each cycle.
    - lock_s=0 -> WAIT_LOCK, with cnt cleared and no loss counted.
    - cnt==LOCK_STABLE-1 with lock_s=1 -> HOLD, cnt cleared.
  - HOLD:
    - SYS_RST_N stays 0; cnt increments.
    - lock_s=0 -> WAIT_LOCK, no loss counted.
    - cnt==RESET_HOLD-1 -> RUN.
  - RUN:
    - SYS_RST_N=1 and READY=1, registered from state and both rising in the same cycle.
    - lock_s=0 -> WAIT_LOCK. SYS_RST_N and READY fall on the same edge as the state change.
    - On that loss: LOSS_CNT increments, saturating at all-ones, and LOSS_STICKY=1.
- Latency:
  - Rise: with PLL_LOCK held high, SYS_RST_N rises exactly SYNC_STAGES+1+LOCK_STABLE+RESET_HOLD rising edges after the first edge that samples PLL_LOCK=1. With defaults this is 1043.
  - Fall: SYS_RST_N falls exactly SYNC_STAGES+1 edges after the first edge that samples PLL_LOCK=0 while in RUN. With defaults this is 3.
- Boundary conditions:
  - Lock glitch shorter than SYNC_STAGES cycles that does not reach lock_s: no effect.
  - Glitch that reaches lock_s during STABILIZE or HOLD: full restart of qualification.
  - CLR_LOSS coinciding with a loss event: the loss wins. Result is LOSS_CNT=1, LOSS_STICKY=1.
  - CLR_LOSS in any state without a loss event: LOSS_CNT=0, LOSS_STICKY=0 next cycle.
  - LOSS_CNT at all-ones plus another loss: stays all-ones, LOSS_STICKY stays 1.
  - BTN_USR asserted in any state: immediate return to the reset values above. After release, re-qualification starts from WAIT_LOCK.
- SYS_RST_N must never pulse high outside RUN (glitch-free, driven from a single flop).

Optional Feature:
- Macro: PLL_LOCK_SEQ_HEARTBEAT_EN.
- When defined:
  - Adds output port LED_HB (1 bit) and a free-running counter that counts only in RUN.
  - The counter is cleared to 0 in every other state and on BTN_USR.
  - LED_HB = counter[HB_BIT] when READY=1, else LED_HB=0.
- When undefined: no LED_HB port, no heartbeat counter; all other behaviour identical.

Test Plan:
- Use LOCK_STABLE=8, RESET_HOLD=4, SYNC_STAGES=2 unless noted.
- Power-up: BTN_USR=0 for 5 cycles, release, PLL_LOCK=1 from cycle 0 -> SYS_RST_N rises exactly 15 edges after first PLL_LOCK=1 sample; READY rises on the same edge; LOSS_CNT=0.
- Early drop: PLL_LOCK drops low for 3 cycles at stable-count 5 -> return to WAIT_LOCK, LOSS_CNT stays 0; after re-assert, SYS_RST_N rises 15 edges later.
- Loss in RUN: drop PLL_LOCK -> SYS_RST_N=0 and READY=0 after 3 edges, LOSS_CNT=1, LOSS_STICKY=1; re-lock -> release 15 edges later.
- Saturation/clear: LOSS_W=2, force 5 losses -> LOSS_CNT=3; CLR_LOSS pulse -> 0/0; CLR_LOSS on a loss edge -> LOSS_CNT=1, LOSS_STICKY=1.
- Mid-operation reset: assert BTN_USR during HOLD and again in RUN -> all outputs immediately at reset values; full 15-edge sequence after release.
- With PLL_LOCK_SEQ_HEARTBEAT_EN, HB_BIT=2 -> LED_HB toggles every 4 cycles in RUN; LED_HB=0 in all other states.
